// File: rtl/data_cache_pkg.sv
// Shared field widths, line count and FSM state encoding for the data cache.
package data_cache_pkg;

    localparam int unsigned TAG_W    = 3;
    localparam int unsigned INDEX_W  = 3;
    localparam int unsigned OFFSET_W = 2;
    localparam int unsigned BLOCK_W  = 32;
    localparam int unsigned LINES    = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StFetch,
        StUpdate
    } state_e;

endpackage

// File: rtl/dcache_storage.sv
// Line storage: valid/dirty/tag/data arrays, async read, single sync write port.
module dcache_storage
    import data_cache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_block,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_block,
    input  logic               wr_dirty
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];

    // Status bits: cleared by reset; any line write marks the line valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
            dirty_q[wr_index] <= wr_dirty;
        end
    end

    // Tag and data are not reset, but a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_block;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_block = data_q[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 bytes.
module data_cache
    import data_cache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [7:0]         ADDRESS,
    input  logic [7:0]         WRITEDATA,
    output logic [7:0]         READDATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [5:0]         MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    state_e state_q, state_d;
    logic [BLOCK_W-1:0] fetch_q, fetch_d;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                access;
    logic                hit;

    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_block;

    logic               wr_en;
    logic [TAG_W-1:0]   wr_tag;
    logic [BLOCK_W-1:0] wr_block;
    logic               wr_dirty;

    assign tag    = ADDRESS[7:5];
    assign index  = ADDRESS[4:2];
    assign offset = ADDRESS[1:0];
    assign access = READ | WRITE;
    assign hit    = line_valid && (line_tag == tag);

    dcache_storage u_storage (
        .clk      (CLK),
        .reset    (RESET),
        .rd_index (index),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_block (line_block),
        .wr_en    (wr_en),
        .wr_index (index),
        .wr_tag   (wr_tag),
        .wr_block (wr_block),
        .wr_dirty (wr_dirty)
    );

    assign READDATA      = line_block[{offset, 3'b000} +: 8];
    assign MEM_WRITEDATA = line_block;

    // State and fetched-block registers; reset aborts any memory transaction.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
        end
    end

    // Next-state, memory handshake and line-write control.
    always_comb begin
        state_d     = state_q;
        fetch_d     = fetch_q;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        MEM_WRITE   = 1'b0;
        MEM_ADDRESS = {tag, index};
        wr_en       = 1'b0;
        wr_tag      = line_tag;
        wr_block    = line_block;
        wr_dirty    = line_dirty;
        case (state_q)
            StIdle: begin
                if (access) begin
                    if (hit) begin
                        // WRITE wins when both strobes are high.
                        if (WRITE) begin
                            wr_en = 1'b1;
                            wr_block[{offset, 3'b000} +: 8] = WRITEDATA;
                            wr_dirty = 1'b1;
                        end
                    end else begin
                        BUSYWAIT = 1'b1;
                        state_d  = (line_valid && line_dirty) ? StWriteback : StFetch;
                    end
                end
            end
            StWriteback: begin
                BUSYWAIT    = access;
                MEM_WRITE   = 1'b1;
                MEM_ADDRESS = {line_tag, index};
                if (!MEM_BUSYWAIT) state_d = StFetch;
            end
            StFetch: begin
                BUSYWAIT = access;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    fetch_d = MEM_READDATA;
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                BUSYWAIT = access;
                wr_en    = 1'b1;
                wr_tag   = tag;
                wr_block = fetch_q;
                wr_dirty = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random accesses
// compared against a byte-level reference cache/memory model.
module tb_data_cache;

    localparam int LAT    = 5;
    localparam int BUDGET = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
    logic        mem_clear;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_cache dut (
        .CLK           (clk),
        .RESET         (rst),
        .READ          (rd),
        .WRITE         (wr),
        .ADDRESS       (addr),
        .WRITEDATA     (wdata),
        .READDATA      (rdata),
        .BUSYWAIT      (busywait),
        .MEM_READ      (mem_read),
        .MEM_WRITE     (mem_write),
        .MEM_ADDRESS   (mem_address),
        .MEM_WRITEDATA (mem_writedata),
        .MEM_READDATA  (mem_readdata),
        .MEM_BUSYWAIT  (mem_busywait)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = 32'(i) * 32'h9E37_79B1;
        return w ^ 32'h5A5A_C3C3;
    endfunction

    // Backing memory: busy from the first request cycle, done after LAT cycles.
    logic [31:0] phys [64];
    int          mcnt = 0;
    logic        mreq;
    assign mreq         = mem_read | mem_write;
    assign mem_busywait = mreq && (mcnt != LAT - 1);
    assign mem_readdata = mem_read ? phys[mem_address] : 32'h0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) phys[i] <= init_word(i);
        end else if (mem_write && !mem_busywait) begin
            phys[mem_address] <= mem_writedata;
        end
        if (!mreq || !mem_busywait) mcnt <= 0;
        else mcnt <= mcnt + 1;
    end

    // Reference model: what each line holds and what memory holds.
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_data  [8];
    logic [31:0] m_mem   [64];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic model_access(input logic r, input logic w, input logic [7:0] a,
                                input logic [7:0] d, output int stall, output logic [7:0] rb,
                                output logic wb, output logic [5:0] wb_a,
                                output logic [31:0] wb_d, output logic fe,
                                output logic [5:0] fe_a);
        int idx;
        int off;
        idx   = int'(a[4:2]);
        off   = int'(a[1:0]);
        stall = 0;
        wb    = 1'b0;
        wb_a  = '0;
        wb_d  = '0;
        fe    = 1'b0;
        fe_a  = '0;
        if (r || w) begin
            if (!(m_valid[idx] && m_tag[idx] == a[7:5])) begin
                fe    = 1'b1;
                fe_a  = a[7:2];
                stall = LAT + 2;
                if (m_valid[idx] && m_dirty[idx]) begin
                    wb    = 1'b1;
                    wb_a  = {m_tag[idx], a[4:2]};
                    wb_d  = m_data[idx];
                    m_mem[wb_a] = m_data[idx];
                    stall = 2 * LAT + 2;
                end
                m_data[idx]  = m_mem[a[7:2]];
                m_tag[idx]   = a[7:5];
                m_valid[idx] = 1'b1;
                m_dirty[idx] = 1'b0;
            end
            if (w) begin
                m_data[idx][off*8 +: 8] = d;
                m_dirty[idx] = 1'b1;
            end
        end
        rb = m_data[idx][off*8 +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request and hold it until BUSYWAIT drops, recording memory traffic.
    task automatic dut_access(input logic r, input logic w, input logic [7:0] a,
                              input logic [7:0] d, output int stalls, output logic [7:0] rb,
                              output logic saw_wb, output logic [5:0] wb_a,
                              output logic [31:0] wb_d, output logic saw_fe,
                              output logic [5:0] fe_a, output logic bad);
        @(posedge clk);
        #1;
        rd = r; wr = w; addr = a; wdata = d;
        #1;
        stalls = 0;
        saw_wb = 1'b0; wb_a = '0; wb_d = '0;
        saw_fe = 1'b0; fe_a = '0;
        bad    = 1'b0;
        while (busywait === 1'b1 && stalls < BUDGET) begin
            if (mem_read && mem_write) bad = 1'b1;
            if (mem_write) begin
                if (saw_wb && (wb_a !== mem_address || wb_d !== mem_writedata)) bad = 1'b1;
                saw_wb = 1'b1;
                wb_a   = mem_address;
                wb_d   = mem_writedata;
            end
            if (mem_read && !saw_fe) begin
                saw_fe = 1'b1;
                fe_a   = mem_address;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        rb = rdata;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    int          d_stall, e_stall;
    logic [7:0]  d_rb, e_rb;
    logic        d_wb, e_wb, d_fe, e_fe, d_bad;
    logic [5:0]  d_wba, e_wba, d_fea, e_fea;
    logic [31:0] d_wbd, e_wbd;

    task automatic run(input string tag, input logic r, input logic w, input logic [7:0] a,
                       input logic [7:0] d);
        model_access(r, w, a, d, e_stall, e_rb, e_wb, e_wba, e_wbd, e_fe, e_fea);
        dut_access(r, w, a, d, d_stall, d_rb, d_wb, d_wba, d_wbd, d_fe, d_fea, d_bad);
        check({tag, ".stall"}, 32'(d_stall), 32'(e_stall));
        check({tag, ".wb"}, 32'(d_wb), 32'(e_wb));
        check({tag, ".fetch"}, 32'(d_fe), 32'(e_fe));
        check({tag, ".proto"}, 32'(d_bad), 32'h0);
        if (e_wb) begin
            check({tag, ".wb_addr"}, 32'(d_wba), 32'(e_wba));
            check({tag, ".wb_data"}, d_wbd, e_wbd);
        end
        if (e_fe) check({tag, ".fe_addr"}, 32'(d_fea), 32'(e_fea));
        if (r && !w) check({tag, ".rdata"}, 32'(d_rb), 32'(e_rb));
    endtask

    initial begin
        int diffs;
        logic [7:0] ra, rdv;
        int k;
        rst = 1'b1; mem_clear = 1'b1;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; mem_clear = 1'b0;
        #1;
        check("reset.busywait", 32'(busywait), 32'h0);
        check("reset.mem_read", 32'(mem_read), 32'h0);
        check("reset.mem_write", 32'(mem_write), 32'h0);

        // Clean miss, then hits in the same line.
        run("rd14", 1'b1, 1'b0, 8'h14, 8'h00);
        check("rd14.fe_addr_spec", 32'(d_fea), 32'h05);
        check("rd14.stall_spec", 32'(d_stall), 32'(LAT + 2));
        check("rd14.byte0", 32'(d_rb), 32'(init_word(5) & 32'hFF));
        run("rd15", 1'b1, 1'b0, 8'h15, 8'h00);
        check("rd15.byte1", 32'(d_rb), 32'((init_word(5) >> 8) & 32'hFF));
        run("wr16", 1'b0, 1'b1, 8'h16, 8'hAB);
        run("rd16", 1'b1, 1'b0, 8'h16, 8'h00);
        check("rd16.value", 32'(d_rb), 32'hAB);
        check("rd16.dirty5", 32'(dut.u_storage.dirty_q[5]), 32'h1);

        // Dirty conflict miss on index 5.
        run("rd34", 1'b1, 1'b0, 8'h34, 8'h00);
        check("rd34.wb_addr_spec", 32'(d_wba), 32'h05);
        check("rd34.wb_byte2", 32'(d_wbd[23:16]), 32'hAB);
        check("rd34.fe_addr_spec", 32'(d_fea), 32'h0D);
        check("rd34.dirty5", 32'(dut.u_storage.dirty_q[5]), 32'h0);

        // READ and WRITE together act as a write.
        run("rw00", 1'b1, 1'b1, 8'h00, 8'h5C);
        run("rd00", 1'b1, 1'b0, 8'h00, 8'h00);
        check("rd00.value", 32'(d_rb), 32'h5C);
        check("rd00.dirty0", 32'(dut.u_storage.dirty_q[0]), 32'h1);

        // Reset while a fetch is outstanding.
        @(posedge clk);
        #1;
        rd = 1'b1; addr = 8'h74;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rstfe.in_fetch", 32'(mem_read), 32'h1);
        rst = 1'b1; rd = 1'b0;
        @(posedge clk);
        #1;
        check("rstfe.mem_read", 32'(mem_read), 32'h0);
        check("rstfe.busywait", 32'(busywait), 32'h0);
        check("rstfe.valid", 32'(dut.u_storage.valid_q), 32'h0);
        rst = 1'b0;
        model_reset();
        run("rstfe.reissue", 1'b1, 1'b0, 8'h34, 8'h00);
        check("rstfe.miss", 32'(d_stall), 32'(LAT + 2));

        // Random traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            ra  = 8'($urandom_range(0, 255));
            rdv = 8'($urandom);
            k   = int'($urandom_range(0, 3));
            case (k)
                0, 3:    run("rand.rd", 1'b1, 1'b0, ra, rdv);
                1:       run("rand.wr", 1'b0, 1'b1, ra, rdv);
                default: run("rand.rw", 1'b1, 1'b1, ra, rdv);
            endcase
        end

        // Memory must match the model's view of everything written back.
        @(posedge clk);
        #1;
        diffs = 0;
        for (int i = 0; i < 64; i++) if (phys[i] !== m_mem[i]) diffs++;
        check("mem.image_diffs", 32'(diffs), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The module SHALL have one clock and synchronous, active-high reset: CLK in 1, rising-edge clock; RESET in 1, synchronous active-high reset.
REQ-002 The module SHALL have these CPU-side ports:
- READ in 1: load request from control unit.
- WRITE in 1: store request from control unit.
- ADDRESS in 8: byte address from ALU.
- WRITEDATA in 8: store data.
- READDATA out 8: load data.
- BUSYWAIT out 1: stall CPU (PC hold).
REQ-003 The module SHALL have these memory-side ports:
- MEM_READ out 1: block fetch request.
- MEM_WRITE out 1: block writeback request.
- MEM_ADDRESS out 6: block address.
- MEM_WRITEDATA out 32: writeback block.
- MEM_READDATA in 32: fetched block.
- MEM_BUSYWAIT in 1: memory busy.

Function
REQ-004 Organisation SHALL be direct-mapped, 8 lines of 4 bytes, write-back, write-allocate; ADDRESS split tag[7:5], index[4:2], offset[1:0].
REQ-005 Per line, state SHALL be: valid bit, dirty bit, 3-bit tag, 32-bit block; byte k of an address with offset k SHALL be block bits [8k+7:8k].
REQ-006 A hit SHALL be valid[index] and tag[index]==ADDRESS[7:5].
REQ-007 Access SHALL be READ or WRITE high; if both are high, the request SHALL be treated as WRITE.
REQ-008 The FSM SHALL have states IDLE, WRITEBACK, FETCH and UPDATE.
REQ-009 Read hit in IDLE: READDATA SHALL equal the addressed byte combinationally in the same cycle, with BUSYWAIT low (zero-stall).
REQ-010 Write hit in IDLE: BUSYWAIT SHALL be low; on the next rising edge the addressed byte SHALL be written and dirty set.
REQ-011 Miss in IDLE: BUSYWAIT SHALL go high combinationally; the next state SHALL be WRITEBACK if valid and dirty, else FETCH.
REQ-012 WRITEBACK SHALL assert MEM_WRITE=1, MEM_ADDRESS={stored tag, index} and MEM_WRITEDATA=stored block, held constant; on the edge where MEM_BUSYWAIT=0 it SHALL go to FETCH.
REQ-013 FETCH SHALL assert MEM_READ=1 and MEM_ADDRESS={ADDRESS[7:5], index}; on the edge where MEM_BUSYWAIT=0 it SHALL go to UPDATE.
REQ-014 On the same edge as REQ-013, the FSM SHALL capture MEM_READDATA.
REQ-015 UPDATE SHALL write the block, tag, valid=1 and dirty=0, then go to IDLE; the pending access SHALL then complete as a hit per REQ-009/010.
REQ-016 BUSYWAIT SHALL be high in WRITEBACK, FETCH and UPDATE whenever READ or WRITE is high.
REQ-017 MEM_READ and MEM_WRITE SHALL never be high together; both SHALL be low in IDLE and UPDATE.
REQ-018 Memory contract: memory SHALL raise MEM_BUSYWAIT in the first cycle a request is high, and lower it in the cycle its data or write is complete.
REQ-019 Miss penalty SHALL be: clean miss = memory latency + 2 cycles; dirty miss = 2 × memory latency + 2 cycles.
REQ-020 With no request in IDLE, BUSYWAIT SHALL be 0 and storage SHALL be unchanged.
REQ-021 READDATA value SHALL be don't-care when READ is low.

Reset
REQ-022 On RESET high at a rising edge, all valid and dirty bits SHALL be cleared and state SHALL go to IDLE.
REQ-023 Reset-state outputs SHALL be BUSYWAIT=0, MEM_READ=0 and MEM_WRITE=0.
REQ-024 Block and tag contents need not be reset.
REQ-025 RESET SHALL take priority over all transitions; reset mid-WRITEBACK or mid-FETCH SHALL abort, and requests SHALL be low in the following cycle, with no line updated.

Structure
REQ-026 A shared package SHALL hold the state encoding, field widths (TAG_W=3, INDEX_W=3, OFFSET_W=2, BLOCK_W=32) and the line count 8.
REQ-027 The storage array SHALL be one natural sub-module, dcache_storage, containing the valid, dirty, tag and data arrays with a sync write port; the FSM and hit logic SHALL remain in data_cache.

Verification
REQ-028 After reset, READ at 0x14 (clean miss, memory latency 5) SHALL give: FETCH with MEM_ADDRESS=0x05; BUSYWAIT high for 7 cycles; then READDATA = byte 0 of the fetched block.
REQ-029 A repeat READ at 0x15 SHALL give BUSYWAIT=0 in the same cycle and READDATA = byte 1 of the block.
REQ-030 WRITE 0xAB at 0x16 (hit) SHALL give zero stall; a subsequent READ 0x16 SHALL return 0xAB with dirty[5]=1.
REQ-031 READ 0x34 (same index 5, tag 1, line dirty) SHALL give: WRITEBACK with MEM_ADDRESS=0x05 and MEM_WRITEDATA containing 0xAB in bits [23:16]; then FETCH with MEM_ADDRESS=0x0D; then UPDATE with dirty[5]=0.
REQ-032 RESET asserted during FETCH SHALL give, in the next cycle, MEM_READ=0, BUSYWAIT=0 and all valid=0; a re-issued READ SHALL miss.
REQ-033 READ and WRITE both high at 0x00 SHALL be handled as WRITE: the byte is written and dirty is set.
